// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0]  PS2_BRK_PREFIX = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser and saturating glitch filter for one PS/2 line, with a
// registered one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_dly;
    logic          r_fall;
    logic [CW-1:0] w_cnt_next;
    logic          w_level_next;

    always_comb begin
        w_level_next = r_level;
        w_cnt_next   = '0;
        // Count only consecutive samples that disagree with the current level.
        if (r_sync[1] != r_level) begin
            if (r_cnt == CW'(FILTER_LEN - 1)) begin
                w_level_next = r_sync[1];
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= 2'b11;
            r_cnt       <= '0;
            r_level     <= 1'b1;
            r_level_dly <= 1'b1;
            r_fall      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_line};
            r_cnt       <= w_cnt_next;
            r_level     <= w_level_next;
            r_level_dly <= r_level;
            r_fall      <= r_level_dly & ~r_level;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver producing validated scan codes with E0/F0 flags.
// Define PS2_BREAK_FILTER_EN to drop break events so only presses reach the output.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_kb_clk,
    input  logic       i_kb_data,
    output logic [7:0] o_sc,
    output logic       o_sc_valid,
    output logic       o_is_break,
    output logic       o_is_ext,
    output logic       o_frame_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic          w_clk_fall;
    logic          w_clk_level_unused;
    logic          w_data;
    logic          w_data_fall_unused;

    ps2_state_e    r_state, w_state_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_parity, w_parity_next;
    logic [TW-1:0] r_to, w_to_next;
    logic          r_ext, w_ext_next;
    logic          r_brk, w_brk_next;
    logic [7:0]    r_sc, w_sc_next;
    logic          r_sc_valid, w_sc_valid_next;
    logic          r_is_break, w_is_break_next;
    logic          r_is_ext, w_is_ext_next;
    logic          r_frame_err, w_frame_err_next;
    logic          w_timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_kb_clk),
        .o_level (w_clk_level_unused),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_kb_data),
        .o_level (w_data),
        .o_fall  (w_data_fall_unused)
    );

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_parity_next    = r_parity;
        w_ext_next       = r_ext;
        w_brk_next       = r_brk;
        w_sc_next        = r_sc;
        w_is_break_next  = r_is_break;
        w_is_ext_next    = r_is_ext;
        w_sc_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        // A strobe in the same cycle as expiry wins, so expiry excludes it.
        w_timeout = (r_state != IDLE) && !w_clk_fall && (r_to == TW'(TIMEOUT_CYCLES - 1));
        w_to_next = ((r_state == IDLE) || w_clk_fall) ? '0 : r_to + TW'(1);

        if (w_timeout) begin
            w_state_next     = IDLE;
            w_frame_err_next = 1'b1;
            w_ext_next       = 1'b0;
            w_brk_next       = 1'b0;
            w_to_next        = '0;
        end else if (w_clk_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_data) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_ext_next       = 1'b0;
                        w_brk_next       = 1'b0;
                    end
                end
                DATA: begin
                    w_shift_next   = {w_data, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_parity_next = w_data;
                    w_state_next  = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    if (w_data && ps2_parity_ok(r_shift, r_parity)) begin
                        if (r_shift == PS2_EXT_PREFIX) begin
                            w_ext_next = 1'b1;
                        end else if (r_shift == PS2_BRK_PREFIX) begin
                            w_brk_next = 1'b1;
                        end else begin
                            w_ext_next = 1'b0;
                            w_brk_next = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
                            if (!r_brk) begin
                                w_sc_next       = r_shift;
                                w_is_ext_next   = r_ext;
                                w_is_break_next = 1'b0;
                                w_sc_valid_next = 1'b1;
                            end
`else
                            w_sc_next       = r_shift;
                            w_is_ext_next   = r_ext;
                            w_is_break_next = r_brk;
                            w_sc_valid_next = 1'b1;
`endif
                        end
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_ext_next       = 1'b0;
                        w_brk_next       = 1'b0;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_to        <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_sc        <= 8'h00;
            r_sc_valid  <= 1'b0;
            r_is_break  <= 1'b0;
            r_is_ext    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_parity    <= w_parity_next;
            r_to        <= w_to_next;
            r_ext       <= w_ext_next;
            r_brk       <= w_brk_next;
            r_sc        <= w_sc_next;
            r_sc_valid  <= w_sc_valid_next;
            r_is_break  <= w_is_break_next;
            r_is_ext    <= w_is_ext_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    assign o_sc        = r_sc;
    assign o_sc_valid  = r_sc_valid;
    assign o_is_break  = r_is_break;
    assign o_is_ext    = r_is_ext;
    assign o_frame_err = r_frame_err;

endmodule
